load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_byte_lane.sv | 38 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared op codes, FSM encoding and request-decode helpers for the load/store unit.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  typedef enum logic [2:0] {
    LSU_LW  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LHU = 3'd2,
    LSU_LB  = 3'd3,
    LSU_LBU = 3'd4,
    LSU_SW  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SB  = 3'd7
  } lsu_op_e;

  // Three bits leave codes 5..7 unused; those recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4
  } lsu_state_e;

  function automatic logic is_load(input lsu_op_e op);
    return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
           (op == LSU_LB) || (op == LSU_LBU);
  endfunction

  function automatic logic is_subword_store(input lsu_op_e op);
    return (op == LSU_SH) || (op == LSU_SB);
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    logic word_op;
    logic half_op;
    word_op = (op == LSU_LW) || (op == LSU_SW);
    half_op = (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
    return (word_op && (off != 2'b00)) || (half_op && off[0]);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  off,
  input  lsu_op_e     op,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{off, 3'b000} +: 8];
    half_sel = rd_word[{off[1], 4'b0000} +: 16];

    ld_data = rd_word;
    case (op)
      LSU_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: ld_data = {16'h0000, half_sel};
      LSU_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: ld_data = {24'h000000, byte_sel};
      default: ld_data = rd_word;
    endcase

    st_word = rd_word;
    case (op)
      LSU_SB:  st_word[{off, 3'b000} +: 8]     = st_data[7:0];
      LSU_SH:  st_word[{off[1], 4'b0000} +: 16] = st_data[15:0];
      LSU_SW:  st_word = st_data;
      default: st_word = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word-indexed access, RMW sub-word stores,
// and a write enable driven straight from a flop.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RAM_AW = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_misalign,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [RAM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_misalign_q, resp_misalign_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  lsu_op_e     req_op_e;

  assign req_op_e = lsu_op_e'(req_op);

  lsu_byte_lane u_lane (
    .rd_word (mem_rdata),
    .st_data (wdata_q),
    .off     (off_q),
    .op      (op_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // req_ready is high exactly when the FSM sits in ST_IDLE.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    off_d           = off_q;
    wdata_d         = wdata_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wren_d      = 1'b0;
    resp_valid_d    = 1'b0;
    resp_data_d     = 32'h0;
    resp_misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op_e;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = req_addr[RAM_AW+1:2];
          if (is_misaligned(req_op_e, req_addr[1:0])) begin
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
          end else if (is_load(req_op_e)) begin
            state_d = ST_LOAD;
          end else if (is_subword_store(req_op_e)) begin
            state_d = ST_RMW_RD;
          end else begin
            state_d     = ST_STORE;
            mem_wdata_d = req_wdata;
            mem_wren_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        resp_data_d  = ld_data;
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_STORE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      // Merge happens against the word read during this cycle; the write follows.
      ST_RMW_RD: begin
        mem_wdata_d = st_word;
        mem_wren_d  = 1'b1;
        state_d     = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      op_q            <= LSU_LW;
      off_q           <= 2'b00;
      wdata_q         <= 32'h0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= 32'h0;
      mem_wren_q      <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= 32'h0;
      resp_misalign_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      off_q           <= off_d;
      wdata_q         <= wdata_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wren_q      <= mem_wren_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_misalign_q <= resp_misalign_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_misalign = resp_misalign_q;
  assign mem_addr      = {{(32-RAM_AW){1'b0}}, mem_addr_q};
  assign mem_wdata     = mem_wdata_q;
  assign mem_wren      = mem_wren_q;

endmodule
